// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler that shares one add/subtract unit between two
// requesters and returns registered results with a one-cycle strobe.
module addsub_rr_scheduler #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic         req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic         req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         au_op_mode,
   output logic [W-1:0] au_data_a,
   output logic [W-1:0] au_data_b,
   input  logic [W-1:0] au_data_s,
   output logic         rsp0_valid,
   output logic         rsp1_valid,
   output logic [W-1:0] rsp_data,
   output logic         rsp_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic rr_ptr;
   logic owner;
   logic grant;
   logic take;
   logic ovf;
   logic sa;
   logic sb;
   logic ss;

   // A lone requester wins outright; rr_ptr only breaks ties.
   always_comb begin
      grant = rr_ptr;
      if (req0_valid && !req1_valid) begin
         grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end
   end

   assign take = req0_ready | req1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (take) begin
               state_nxt = EXEC;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      if (rst_n && state == IDLE) begin
         req0_ready = !grant && req0_valid;
         req1_ready = grant && req1_valid;
      end
      if (state == RESP) begin
         rsp0_valid = !owner;
         rsp1_valid = owner;
      end
   end

   // Signed overflow from the operand and result sign bits.
   always_comb begin
      sa  = au_data_a[W-1];
      sb  = au_data_b[W-1];
      ss  = au_data_s[W-1];
      ovf = 1'b0;
      if (au_op_mode) begin
         ovf = (sa != sb) && (ss != sa);
      end else begin
         ovf = (sa == sb) && (ss != sa);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         au_op_mode <= 1'b0;
         au_data_a  <= '0;
         au_data_b  <= '0;
         owner      <= 1'b0;
         rr_ptr     <= 1'b0;
         rsp_data   <= '0;
         rsp_ovf    <= 1'b0;
      end else begin
         if (take) begin
            owner      <= grant;
            au_op_mode <= grant ? req1_op : req0_op;
            au_data_a  <= grant ? req1_a : req0_a;
            au_data_b  <= grant ? req1_b : req0_b;
         end
         if (state == EXEC) begin
            rsp_data <= au_data_s;
            rsp_ovf  <= ovf;
         end
         if (state == RESP) begin
            rr_ptr <= ~owner;
         end
      end
   end

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Bench for addsub_rr_scheduler: directed vectors plus a cycle-level
// reference model of arbitration, latency and arithmetic.
module tb_addsub_rr_scheduler;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req0_ready, req0_op;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_op;
   logic [W-1:0] req1_a, req1_b;
   logic         au_op_mode;
   logic [W-1:0] au_data_a, au_data_b, au_data_s;
   logic         rsp0_valid, rsp1_valid;
   logic [W-1:0] rsp_data;
   logic         rsp_ovf;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   addsub_rr_scheduler #(.W(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_op(req0_op),
      .req0_a(req0_a),
      .req0_b(req0_b),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_op(req1_op),
      .req1_a(req1_a),
      .req1_b(req1_b),
      .au_op_mode(au_op_mode),
      .au_data_a(au_data_a),
      .au_data_b(au_data_b),
      .au_data_s(au_data_s),
      .rsp0_valid(rsp0_valid),
      .rsp1_valid(rsp1_valid),
      .rsp_data(rsp_data),
      .rsp_ovf(rsp_ovf)
   );

   // The shared add/subtract unit.
   assign au_data_s = au_op_mode ? au_data_a - au_data_b
                                 : au_data_a + au_data_b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endfunction

   function automatic void timeout(string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout at cycle %0d", nm, cyc);
   endfunction

   // Reference model: a handshake at cycle n gives latched operands
   // from n+1, the response at n+2, and a free scheduler from n+3.
   bit         pend = 0;
   int         hs = 0;
   bit         own = 0;
   bit         pref = 0;
   bit         c_op = 0;
   bit         c_ovf = 0;
   logic [7:0] c_a = 0, c_b = 0, c_s = 0;
   bit         e_op = 0;
   bit         e_ovf = 0;
   logic [7:0] e_a = 0, e_b = 0, e_s = 0;

   always @(negedge clk) begin
      bit free, er0, er1, ev0, ev1;
      int sa, sb, r;
      ev0 = 0;
      ev1 = 0;
      if (!rst_n) begin
         pend  = 0;
         pref  = 0;
         e_op  = 0;
         e_a   = 0;
         e_b   = 0;
         e_s   = 0;
         e_ovf = 0;
      end else if (pend) begin
         if (cyc == hs + 1) begin
            e_op = c_op;
            e_a  = c_a;
            e_b  = c_b;
         end
         if (cyc == hs + 2) begin
            e_s   = c_s;
            e_ovf = c_ovf;
            ev0   = !own;
            ev1   = own;
         end
         if (cyc >= hs + 3) pend = 0;
      end
      free = rst_n && !pend;
      er0 = free && req0_valid && (!req1_valid || !pref);
      er1 = free && req1_valid && (!req0_valid || pref);
      chk("req0_ready", req0_ready, er0);
      chk("req1_ready", req1_ready, er1);
      chk("rsp0_valid", rsp0_valid, ev0);
      chk("rsp1_valid", rsp1_valid, ev1);
      chk("rsp_data", rsp_data, e_s);
      chk("rsp_ovf", rsp_ovf, e_ovf);
      chk("au_op_mode", au_op_mode, e_op);
      chk("au_data_a", au_data_a, e_a);
      chk("au_data_b", au_data_b, e_b);
      if (er0 || er1) begin
         pend = 1;
         hs   = cyc;
         own  = er1;
         pref = !er1;
         c_op = er1 ? req1_op : req0_op;
         c_a  = er1 ? req1_a : req0_a;
         c_b  = er1 ? req1_b : req0_b;
         sa   = int'($signed(c_a));
         sb   = int'($signed(c_b));
         r    = c_op ? sa - sb : sa + sb;
         c_s  = r[7:0];
         c_ovf = (r > 127) || (r < -128);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input bit v, input bit op,
                        input logic [7:0] a, input logic [7:0] b);
      if (k == 0) begin
         req0_valid = v;
         req0_op    = op;
         req0_a     = a;
         req0_b     = b;
      end else begin
         req1_valid = v;
         req1_op    = op;
         req1_a     = a;
         req1_b     = b;
      end
   endtask

   // Present a request, hold it until ready, release after the edge.
   task automatic do_op(input int k, input bit op,
                        input logic [7:0] a, input logic [7:0] b);
      int t;
      drive(k, 1, op, a, b);
      t = 0;
      @(negedge clk);
      while (!(k == 1 ? req1_ready : req0_ready) && t < 30) begin
         @(negedge clk);
         t++;
      end
      if (t >= 30) timeout("handshake");
      step();
      drive(k, 0, op, a, b);
   endtask

   task automatic expect_rsp(input int k, input logic [7:0] d,
                             input bit o, input string nm);
      int t;
      t = 0;
      @(negedge clk);
      while (!(k == 1 ? rsp1_valid : rsp0_valid) && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         timeout(nm);
      end else begin
         chk({nm, "_data"}, rsp_data, d);
         chk({nm, "_ovf"}, rsp_ovf, o);
      end
   endtask

   initial begin
      int t, last, c0, c1;
      rst_n = 0;
      drive(0, 0, 0, 8'h00, 8'h00);
      drive(1, 0, 0, 8'h00, 8'h00);
      repeat (3) step();
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_ready0", req0_ready, 0);

      // Basic add and its latency
      rst_n = 1;
      step();
      drive(0, 1, 0, 8'h05, 8'h03);
      @(negedge clk);
      chk("t1_ready_same_cycle", req0_ready, 1);
      last = cyc;
      step();
      drive(0, 0, 0, 8'h05, 8'h03);
      expect_rsp(0, 8'h08, 0, "t1");
      chk("t1_latency", cyc - last, 2);

      // Wrap and overflow on requester 1
      do_op(1, 0, 8'h7F, 8'h01);
      expect_rsp(1, 8'h80, 1, "ovf_add");
      do_op(1, 1, 8'h00, 8'h01);
      expect_rsp(1, 8'hFF, 0, "wrap_sub");
      do_op(1, 1, 8'h80, 8'h01);
      expect_rsp(1, 8'h7F, 1, "ovf_sub");
      repeat (2) step();

      // Contention from reset, alternating grants
      rst_n = 0;
      drive(0, 1, 0, 8'h10, 8'h01);
      drive(1, 1, 1, 8'h20, 8'h01);
      repeat (2) step();
      rst_n = 1;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               t = 0;
               @(negedge clk);
               while (!(req0_ready || req1_ready) && t < 20) begin
                  @(negedge clk);
                  t++;
               end
               if (t >= 20) timeout("alt_wait");
               else chk("alt_grant", req1_ready, i % 2);
               step();
            end
            drive(0, 0, 0, 8'h10, 8'h01);
            drive(1, 0, 1, 8'h20, 8'h01);
         end
         begin
            expect_rsp(0, 8'h11, 0, "cont0");
            expect_rsp(1, 8'h1F, 0, "cont1");
         end
      join
      repeat (3) step();

      // Lone requester 1 while rr_ptr favours requester 0
      drive(1, 1, 0, 8'h40, 8'h40);
      last = 0;
      for (int i = 0; i < 4; i++) begin
         t = 0;
         @(negedge clk);
         while (!(req0_ready || req1_ready) && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (t >= 20) begin
            timeout("lone_wait");
         end else begin
            chk("lone_grant", req1_ready, 1);
            if (i > 0) chk("lone_spacing", cyc - last, 3);
            last = cyc;
         end
         step();
      end
      drive(1, 0, 0, 8'h40, 8'h40);
      repeat (3) step();

      // Reset during EXEC aborts the op; pending req1 survives
      do_op(0, 0, 8'h01, 8'h02);
      drive(1, 1, 1, 8'h30, 8'h05);
      rst_n = 0;
      #1;
      chk("rst_async_au_a", au_data_a, 0);
      chk("rst_async_rsp_data", rsp_data, 0);
      chk("rst_async_rsp0", rsp0_valid, 0);
      repeat (2) step();
      rst_n = 1;
      t = 0;
      @(negedge clk);
      while (!req1_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) timeout("rst_req1_wait");
      step();
      drive(1, 0, 1, 8'h30, 8'h05);
      expect_rsp(1, 8'h2B, 0, "rst_req1");
      repeat (2) step();

      // Withdrawn req1 pulse during EXEC of req0
      do_op(0, 0, 8'h22, 8'h11);
      drive(1, 1, 0, 8'h01, 8'h01);
      step();
      drive(1, 0, 0, 8'h01, 8'h01);
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         c0 += int'(rsp0_valid);
         c1 += int'(rsp1_valid);
      end
      chk("wd_rsp0_count", c0, 1);
      chk("wd_rsp1_count", c1, 0);
      chk("wd_rsp_data", rsp_data, 8'h33);
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
- Shares one combinational add/subtract unit between two requesters using round-robin arbitration.
- Each request carries an operation mode and two W-bit operands. The scheduler latches the granted request, drives the shared unit, registers the result and returns it with a one-cycle response strobe to the requester that issued it.
- Sits between the requesting datapath stages (e.g. exponent/mantissa alignment paths) and the single add_subtract instance.

Parameters:
W, 8, operand/result width in bits; must match the shared add/subtract unit.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a request pending
req0_ready  output  1  requester 0 request accepted this cycle
req0_op  input  1  requester 0 mode: 0 = add, 1 = subtract
req0_a  input  W  requester 0 operand A
req0_b  input  W  requester 0 operand B
req1_valid  input  1  requester 1 has a request pending
req1_ready  output  1  requester 1 request accepted this cycle
req1_op  input  1  requester 1 mode
req1_a  input  W  requester 1 operand A
req1_b  input  W  requester 1 operand B
au_op_mode  output  1  mode to shared unit (registered)
au_data_a  output  W  operand A to shared unit (registered)
au_data_b  output  W  operand B to shared unit (registered)
au_data_s  input  W  result from shared unit (combinational from au_* outputs)
rsp0_valid  output  1  one-cycle strobe: result for requester 0 on rsp_data
rsp1_valid  output  1  one-cycle strobe: result for requester 1 on rsp_data
rsp_data  output  W  registered result, held until the next result is captured
rsp_ovf  output  1  signed two's-complement overflow of the result, same timing as rsp_data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=0 (requester 0 preferred).
  - All outputs 0: au_op_mode, au_data_a, au_data_b, rsp_data, rsp_ovf, rsp0_valid, rsp1_valid.
  - Reset asserted mid-operation aborts the operation; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, the requester indexed by rr_ptr.
  - reqK_ready = (state==IDLE) && grant==K && reqK_valid. This is combinational, and at most one ready is high in any cycle.
  - On handshake: latch reqK_op/a/b into au_*, record owner=K, go to EXEC.
  - With no valid requester: stay in IDLE, au_* hold their values.
- EXEC: capture au_data_s into rsp_data; compute rsp_ovf; go to RESP.
- RESP:
  - Assert rsp{owner}_valid for exactly one cycle.
  - rr_ptr <= ~owner.
  - Go to IDLE.
- Latency: handshake at edge T, rsp_valid high during cycle T+2. Throughput is at most one operation per 3 cycles. No new request is accepted in EXEC or RESP.
- Requester rules: valid, op, a and b must stay stable until ready. Deasserting valid before ready withdraws the request; the scheduler must tolerate this.
- Arithmetic: rsp_data = (a ± b) mod 2^W, taken from the shared unit unchanged.
- Overflow:
  - add: rsp_ovf = (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]).
  - sub: rsp_ovf = (a[W-1]!=b[W-1]) && (s[W-1]!=a[W-1]).
  - a and b are the latched au_* operands.
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1…
  - A lone requester is granted back-to-back regardless of rr_ptr.
  - rr_ptr is updated only in RESP.
- rsp_data and rsp_ovf hold their values outside RESP until the next EXEC.

Test Plan:
- Reset: rst_n=0 → all outputs 0, both ready=0. Release reset, req0 add 0x05+0x03 → req0_ready in the same cycle, rsp0_valid 2 cycles later, rsp_data=0x08, rsp_ovf=0.
- Wrap/overflow (W=8): req1 add 0x7F+0x01 → rsp_data=0x80, rsp_ovf=1. Then sub 0x00−0x01 → rsp_data=0xFF, rsp_ovf=0. Then sub 0x80−0x01 → rsp_data=0x7F, rsp_ovf=1.
- Contention: both valid from reset, req0 0x10+0x01 and req1 0x20−0x01 → req0 granted first (rsp0_valid, 0x11), then req1 (rsp1_valid, 0x1F). With both held valid, grants continue to alternate 0,1,0,1 over 8 operations.
- Lone requester: req1 valid for 4 consecutive ops with rr_ptr=0 → every op granted to req1. Each rsp1_valid is exactly 1 cycle; handshakes are spaced exactly 3 cycles apart.
- Reset mid-op: assert rst_n=0 during EXEC → no rsp strobe, outputs 0 immediately (async). After release, a pending req1 is still served correctly.
- Withdrawal: req1_valid pulses for 1 cycle while the scheduler is in EXEC for req0 → req1 is never acknowledged and no rsp1_valid occurs.
